// File: rtl/imm_decode_stage_if.sv
// imm_decode_stage_if: fetch-side and execute-side handshake for the
// immediate-decode stage, plus the pipeline-redirect flush.
// The master modport is the driver/consumer side; slave is the stage itself.
interface imm_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     ir;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            illegal;

    modport master (
        output flush, in_valid, ir, out_ready,
        input  in_ready, out_valid, imm, imm_type, illegal
    );

    modport slave (
        input  flush, in_valid, ir, out_ready,
        output in_ready, out_valid, imm, imm_type, illegal
    );
endinterface

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered RISC-V immediate decoder between fetch and
// execute. Each accepted instruction is classified by opcode, its immediate
// is extracted and sign/zero-extended to XLEN, and the result is queued in a
// DEPTH-entry FIFO read out on a valid/ready handshake.
// Optional feature: define IMM_ZICSR_EN to decode Zicsr immediates (CSR
// address and zimm) from SYSTEM instructions; otherwise SYSTEM decodes as
// NONE and immediate type 7 is never produced.
module imm_decode_stage #(
    parameter int XLEN  = 32,   // 32 or 64
    parameter int DEPTH = 2     // power of two, >= 2
) (
    input logic               clk,
    input logic               rst,
    imm_decode_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZIMM  = 3'd7
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       kind;
        logic            ill;
    } entry_t;

    // Sign-extend a 32-bit pre-assembled immediate to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Zero-extend a 32-bit pre-assembled immediate to XLEN.
    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift;

    assign opcode   = bus.ir[6:0];
    assign funct3   = bus.ir[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    entry_t dec;

    // Combinational decode of the incoming instruction word.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case leaves a latch.
        dec.imm  = '0;
        dec.kind = IMM_NONE;
        dec.ill  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec.kind = IMM_U;
                dec.imm  = sext32({bus.ir[31:12], 12'b0});
            end
            OPC_JAL: begin
                dec.kind = IMM_J;
                dec.imm  = sext32({{11{bus.ir[31]}}, bus.ir[31], bus.ir[19:12],
                                   bus.ir[20], bus.ir[30:21], 1'b0});
            end
            OPC_JALR, OPC_LOAD: begin
                dec.kind = IMM_I;
                dec.imm  = sext32({{20{bus.ir[31]}}, bus.ir[31:20]});
            end
            OPC_OP_IMM: begin
                if (!is_shift) begin
                    dec.kind = IMM_I;
                    dec.imm  = sext32({{20{bus.ir[31]}}, bus.ir[31:20]});
                end else if (XLEN == 64) begin
                    dec.kind = IMM_SHAMT;
                    dec.imm  = zext32({26'b0, bus.ir[25:20]});
                end else if (bus.ir[25]) begin
                    // shamt >= 32 cannot exist on RV32
                    dec.ill = 1'b1;
                end else begin
                    dec.kind = IMM_SHAMT;
                    dec.imm  = zext32({27'b0, bus.ir[24:20]});
                end
            end
            OPC_OP_IMM32: begin
                if (XLEN != 64) begin
                    dec.ill = 1'b1;
                end else if (is_shift) begin
                    dec.kind = IMM_SHAMT;
                    dec.imm  = zext32({27'b0, bus.ir[24:20]});
                end else begin
                    dec.kind = IMM_I;
                    dec.imm  = sext32({{20{bus.ir[31]}}, bus.ir[31:20]});
                end
            end
            OPC_STORE: begin
                dec.kind = IMM_S;
                dec.imm  = sext32({{20{bus.ir[31]}}, bus.ir[31:25], bus.ir[11:7]});
            end
            OPC_BRANCH: begin
                dec.kind = IMM_B;
                dec.imm  = sext32({{19{bus.ir[31]}}, bus.ir[31], bus.ir[7],
                                   bus.ir[30:25], bus.ir[11:8], 1'b0});
            end
            OPC_OP: begin
                dec.kind = IMM_NONE;
            end
            OPC_OP32: begin
                dec.ill = (XLEN != 64);
            end
            OPC_SYSTEM: begin
`ifdef IMM_ZICSR_EN
                case (funct3)
                    3'b101, 3'b110, 3'b111: begin
                        dec.kind = IMM_ZIMM;
                        dec.imm  = zext32({27'b0, bus.ir[19:15]});
                    end
                    3'b001, 3'b010, 3'b011: begin
                        // CSR address travels in the I-immediate field
                        dec.kind = IMM_I;
                        dec.imm  = sext32({{20{bus.ir[31]}}, bus.ir[31:20]});
                    end
                    3'b000: begin
                        dec.kind = IMM_NONE;
                    end
                    default: begin
                        dec.ill = 1'b1;
                    end
                endcase
`else
                dec.kind = IMM_NONE;
`endif
            end
            default: begin
                dec.ill = 1'b1;
            end
        endcase
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    entry_t        mem [DEPTH];
    logic          push;
    logic          pop;

    // Ready depends only on the registered count, never on out_ready.
    assign bus.in_ready  = (count < FULL);
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Queue bookkeeping; flush and reset both empty the queue and beat any push/pop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; a write during flush/reset lands in a slot the pointers no longer reach.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count alone decides which entries are visible.
        if (push) mem[wr_ptr] <= dec;
    end

    assign bus.imm      = bus.out_valid ? mem[rd_ptr].imm       : '0;
    assign bus.imm_type = bus.out_valid ? 3'(mem[rd_ptr].kind)  : 3'd0;
    assign bus.illegal  = bus.out_valid ? mem[rd_ptr].ill       : 1'b0;

endmodule
